// File: rtl/stop_watch_ctrl_if.sv
// Button/counter/display bundle between the board side and the stopwatch control sequencer.
// master = board/datapath side, slave = stop_watch_ctrl.
interface stop_watch_ctrl_if;
  logic [1:0]  btn;
  logic [15:0] cur_value;
  logic        run_en;
  logic        cnt_clear;
  logic [15:0] disp_value;
  logic        lap_active;
  logic [1:0]  state;

  modport master (
    output btn,
    output cur_value,
    input  run_en,
    input  cnt_clear,
    input  disp_value,
    input  lap_active,
    input  state
  );

  modport slave (
    input  btn,
    input  cur_value,
    output run_en,
    output cnt_clear,
    output disp_value,
    output lap_active,
    output state
  );
endinterface

// File: rtl/stop_watch_ctrl.sv
// Stopwatch control: button debounce, IDLE/RUN/LAP/PAUSE sequencing, count enable/clear and lap display select.
// Optional long-press clear on btn[1] is enabled by defining BTN_HOLD_CLEAR_EN.
module stop_watch_ctrl #(
  parameter int DEB_TICKS    = 100000,
  parameter int DEB_SAMPLES  = 4,
  parameter int HOLD_SAMPLES = 1000
) (
  input  logic              clk,
  input  logic              reset_p,
  stop_watch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    LAP   = 2'b10,
    PAUSE = 2'b11
  } state_t;

  localparam int TICK_W = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DEB_TICKS - 1);

  if (DEB_TICKS < 1 || DEB_SAMPLES < 2 || HOLD_SAMPLES < 1) begin : g_param_check
    $error("stop_watch_ctrl: DEB_TICKS>=1, DEB_SAMPLES>=2 and HOLD_SAMPLES>=1 are required");
  end

  logic [1:0]                    btn_meta;
  logic [1:0]                    btn_sync;
  logic [TICK_W-1:0]             tick_cnt;
  logic                          sample_tick;
  logic [1:0][DEB_SAMPLES-1:0]   deb_shift;
  logic [1:0][DEB_SAMPLES-1:0]   shift_next;
  logic [1:0]                    deb_level;
  logic [1:0]                    deb_prev;
  logic [1:0]                    press;
  logic                          hold_fire;

  state_t       state_q;
  logic [15:0]  lap_reg;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      btn_meta <= '0;
      btn_sync <= '0;
      tick_cnt <= '0;
    end else begin
      btn_meta <= bus.btn;
      btn_sync <= btn_meta;
      tick_cnt <= sample_tick ? '0 : tick_cnt + 1'b1;
    end
  end

  assign sample_tick = (tick_cnt == TICK_LAST);

  always_comb begin
    shift_next = deb_shift;
    for (int b = 0; b < 2; b++) begin
      shift_next[b] = {deb_shift[b][DEB_SAMPLES-2:0], btn_sync[b]};
    end
  end

  // The level only moves once the whole sample window agrees, so short bounces never reach the FSM.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      deb_shift <= '0;
      deb_level <= '0;
      deb_prev  <= '0;
    end else begin
      deb_prev <= deb_level;
      if (sample_tick) begin
        deb_shift <= shift_next;
        for (int b = 0; b < 2; b++) begin
          if (&shift_next[b]) begin
            deb_level[b] <= 1'b1;
          end else if (~|shift_next[b]) begin
            deb_level[b] <= 1'b0;
          end
        end
      end
    end
  end

  assign press = deb_level & ~deb_prev;

`ifdef BTN_HOLD_CLEAR_EN
  localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_armed;

  // Fires once per continuous hold; a release is needed before it can fire again.
  assign hold_fire = sample_tick && deb_level[1] && hold_armed &&
                     (hold_cnt == HOLD_W'(HOLD_SAMPLES - 1));

  always_ff @(posedge clk) begin
    if (reset_p) begin
      hold_cnt   <= '0;
      hold_armed <= 1'b1;
    end else if (!deb_level[1]) begin
      hold_cnt   <= '0;
      hold_armed <= 1'b1;
    end else if (hold_fire) begin
      hold_armed <= 1'b0;
    end else if (sample_tick && hold_armed) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign hold_fire = 1'b0;
`endif

  // Outputs are registered alongside the state so disp_value/lap_active always agree with the new state.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q        <= IDLE;
      lap_reg        <= '0;
      bus.run_en     <= 1'b0;
      bus.cnt_clear  <= 1'b0;
      bus.disp_value <= '0;
      bus.lap_active <= 1'b0;
    end else begin
      bus.cnt_clear  <= 1'b0;
      bus.disp_value <= bus.cur_value;
      bus.lap_active <= 1'b0;
      case (state_q)
        IDLE: begin
          if (press[0]) begin
            state_q    <= RUN;
            bus.run_en <= 1'b1;
          end
        end
        RUN: begin
          if (press[0]) begin
            state_q    <= PAUSE;
            bus.run_en <= 1'b0;
          end else if (press[1]) begin
            state_q        <= LAP;
            lap_reg        <= bus.cur_value;
            bus.lap_active <= 1'b1;
          end
        end
        LAP: begin
          if (press[0]) begin
            state_q    <= PAUSE;
            bus.run_en <= 1'b0;
          end else if (!press[1]) begin
            bus.disp_value <= lap_reg;
            bus.lap_active <= 1'b1;
          end else begin
            state_q <= RUN;
          end
        end
        PAUSE: begin
          if (press[0]) begin
            state_q    <= RUN;
            bus.run_en <= 1'b1;
          end else if (press[1]) begin
            state_q       <= IDLE;
            bus.cnt_clear <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          bus.run_en <= 1'b0;
        end
      endcase
      if (hold_fire) begin
        state_q        <= IDLE;
        bus.run_en     <= 1'b0;
        bus.cnt_clear  <= 1'b1;
        bus.disp_value <= bus.cur_value;
        bus.lap_active <= 1'b0;
      end
    end
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Self-checking bench for stop_watch_ctrl: directed button scenarios plus a cycle-level reference model.
// Long-press expectations depend on BTN_HOLD_CLEAR_EN.
module tb_stop_watch_ctrl;

  localparam int DT = 4;
  localparam int DS = 3;
  localparam int HS = 5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_LAP   = 2'd2;
  localparam logic [1:0] S_PAUSE = 2'd3;

  logic clk = 1'b0;
  logic reset_p;
  int   checks = 0;
  int   failures = 0;
  int   clear_count = 0;
  int   c0;

  always #5 clk = ~clk;

  stop_watch_ctrl_if bus();

  stop_watch_ctrl #(
    .DEB_TICKS(DT),
    .DEB_SAMPLES(DS),
    .HOLD_SAMPLES(HS)
  ) dut (
    .clk(clk),
    .reset_p(reset_p),
    .bus(bus)
  );

  // Reference model: buttons are seen two edges late, sampled every DT edges,
  // a level is accepted once DS samples agree, and its rising edge is acted on one cycle later.
  bit          model_valid = 1'b0;
  int          m_n;
  logic [1:0]  m_raw_q [2];
  logic [1:0]  m_hist [$];
  logic [1:0]  m_level;
  logic [1:0]  m_rose;
  logic [1:0]  m_state;
  logic [15:0] m_lap;
  int          m_hc;
  bit          m_armed;
  logic [1:0]  exp_state;
  logic        exp_run;
  logic        exp_clear;
  logic        exp_lap;
  logic [15:0] exp_disp;

  always @(posedge clk) begin
    logic [1:0] p;
    logic [1:0] lvl_new;
    logic [1:0] nxt;
    logic       clr;
    bit         fire;
    bit         all1;
    bit         all0;
    if (reset_p) begin
      m_n = 0;
      m_raw_q[0] = 2'b00;
      m_raw_q[1] = 2'b00;
      m_hist.delete();
      for (int i = 0; i < DS; i++) m_hist.push_back(2'b00);
      m_level = 2'b00;
      m_rose = 2'b00;
      m_state = S_IDLE;
      m_lap = 16'h0000;
      m_hc = 0;
      m_armed = 1'b1;
      exp_state = S_IDLE;
      exp_run = 1'b0;
      exp_clear = 1'b0;
      exp_lap = 1'b0;
      exp_disp = 16'h0000;
      model_valid = 1'b1;
    end else begin
      p = m_rose;
      m_n = m_n + 1;
      nxt = m_state;
      clr = 1'b0;
      if (p[0]) begin
        if (m_state == S_IDLE || m_state == S_PAUSE) nxt = S_RUN;
        else nxt = S_PAUSE;
      end else if (p[1]) begin
        if (m_state == S_RUN) begin
          nxt = S_LAP;
          m_lap = bus.cur_value;
        end else if (m_state == S_LAP) begin
          nxt = S_RUN;
        end else if (m_state == S_PAUSE) begin
          nxt = S_IDLE;
          clr = 1'b1;
        end
      end
      lvl_new = m_level;
      fire = 1'b0;
      if (m_n % DT == 0) begin
        if (m_level[1] && m_armed) begin
          m_hc = m_hc + 1;
          if (m_hc == HS) begin
            fire = 1'b1;
            m_armed = 1'b0;
          end
        end
        m_hist.push_front(m_raw_q[1]);
        void'(m_hist.pop_back());
        for (int b = 0; b < 2; b++) begin
          all1 = 1'b1;
          all0 = 1'b1;
          foreach (m_hist[i]) begin
            if (m_hist[i][b]) all0 = 1'b0;
            else all1 = 1'b0;
          end
          if (all1) lvl_new[b] = 1'b1;
          else if (all0) lvl_new[b] = 1'b0;
        end
      end
      if (!m_level[1]) begin
        m_hc = 0;
        m_armed = 1'b1;
      end
      m_rose = lvl_new & ~m_level;
      m_level = lvl_new;
      m_raw_q[1] = m_raw_q[0];
      m_raw_q[0] = bus.btn;
`ifdef BTN_HOLD_CLEAR_EN
      if (fire) begin
        nxt = S_IDLE;
        clr = 1'b1;
      end
`endif
      m_state = nxt;
      exp_state = nxt;
      exp_run = (nxt == S_RUN) || (nxt == S_LAP);
      exp_clear = clr;
      exp_lap = (nxt == S_LAP);
      exp_disp = exp_lap ? m_lap : bus.cur_value;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("model_state", 16'(bus.state), 16'(exp_state));
      checkOutput("model_run_en", 16'(bus.run_en), 16'(exp_run));
      checkOutput("model_cnt_clear", 16'(bus.cnt_clear), 16'(exp_clear));
      checkOutput("model_lap_active", 16'(bus.lap_active), 16'(exp_lap));
      checkOutput("model_disp_value", bus.disp_value, exp_disp);
    end
    if (reset_p === 1'b0 && bus.cnt_clear === 1'b1) clear_count++;
  end

  task automatic applyStimulus(input logic [1:0] b, input logic [15:0] cur, input int cycles);
    bus.btn = b;
    bus.cur_value = cur;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic waitState(input string name, input logic [1:0] exp, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (bus.state === exp) hit = 1'b1;
    end
    checkOutput(name, 16'(bus.state), 16'(exp));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    reset_p = 1'b1;
    bus.btn = 2'b11;
    bus.cur_value = 16'h0000;

    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_state", 16'(bus.state), 16'h0000);
      checkOutput("reset_run_en", 16'(bus.run_en), 16'h0000);
      checkOutput("reset_cnt_clear", 16'(bus.cnt_clear), 16'h0000);
      checkOutput("reset_disp", bus.disp_value, 16'h0000);
    end
    reset_p = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_state", 16'(bus.state), 16'h0000);
    checkOutput("post_reset_run_en", 16'(bus.run_en), 16'h0000);
    checkOutput("post_reset_cnt_clear", 16'(bus.cnt_clear), 16'h0000);
    checkOutput("post_reset_disp", bus.disp_value, 16'h0000);
    applyStimulus(2'b00, 16'h0000, 20);
    checkOutput("idle_after_reset", 16'(bus.state), 16'(S_IDLE));

    // Bouncing start button: every sample window is mixed, so nothing qualifies until it settles.
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i % 2 == 0) ? 2'b01 : 2'b00, 16'h0000, 3);
    end
    checkOutput("bounce_rejected", 16'(bus.state), 16'(S_IDLE));
    applyStimulus(2'b01, 16'h0000, 0);
    waitState("bounce_run", S_RUN, 2 + DT * DS + 1 + 2);
    checkOutput("bounce_run_en", 16'(bus.run_en), 16'h0001);
    applyStimulus(2'b01, 16'h0000, 10);
    applyStimulus(2'b00, 16'h0000, 24);
    checkOutput("release_no_effect", 16'(bus.state), 16'(S_RUN));

    applyStimulus(2'b10, 16'h0042, 0);
    waitState("lap_enter", S_LAP, 20);
    checkOutput("lap_disp_capture", bus.disp_value, 16'h0042);
    checkOutput("lap_active_set", 16'(bus.lap_active), 16'h0001);
    applyStimulus(2'b10, 16'h0050, 3);
    checkOutput("lap_disp_frozen", bus.disp_value, 16'h0042);
    checkOutput("lap_still_counting", 16'(bus.run_en), 16'h0001);
    applyStimulus(2'b00, 16'h0050, 24);
    applyStimulus(2'b10, 16'h0050, 0);
    waitState("lap_exit", S_RUN, 20);
    checkOutput("lap_exit_disp", bus.disp_value, 16'h0050);
    checkOutput("lap_exit_active", 16'(bus.lap_active), 16'h0000);
    applyStimulus(2'b10, 16'h0051, 1);
    checkOutput("disp_follows_live", bus.disp_value, 16'h0051);
    applyStimulus(2'b00, 16'h0051, 24);

    applyStimulus(2'b01, 16'h0051, 0);
    waitState("pause_enter", S_PAUSE, 20);
    checkOutput("pause_run_en", 16'(bus.run_en), 16'h0000);
    applyStimulus(2'b00, 16'h0051, 24);
    c0 = clear_count;
    applyStimulus(2'b10, 16'h0051, 0);
    waitState("clear_idle", S_IDLE, 20);
    checkOutput("clear_pulse_high", 16'(bus.cnt_clear), 16'h0001);
    applyStimulus(2'b10, 16'h0051, 1);
    checkOutput("clear_pulse_low", 16'(bus.cnt_clear), 16'h0000);
    applyStimulus(2'b00, 16'h0051, 24);
    checkOutput("clear_pulse_count", 16'(clear_count - c0), 16'h0001);

    // Both buttons qualify on the same sample: start/stop takes priority.
    applyStimulus(2'b01, 16'h0051, 0);
    waitState("simul_pre_run", S_RUN, 20);
    applyStimulus(2'b00, 16'h0051, 24);
    applyStimulus(2'b11, 16'h0077, 0);
    waitState("simul_pause", S_PAUSE, 20);
    checkOutput("simul_no_lap", 16'(bus.lap_active), 16'h0000);
    checkOutput("simul_disp_live", bus.disp_value, 16'h0077);
    applyStimulus(2'b00, 16'h0077, 24);
    checkOutput("simul_release", 16'(bus.state), 16'(S_PAUSE));

    applyStimulus(2'b01, 16'h0077, 0);
    waitState("hold_pre_run", S_RUN, 20);
    applyStimulus(2'b00, 16'h0077, 24);
    c0 = clear_count;
    applyStimulus(2'b10, 16'h0123, 0);
    waitState("hold_lap_first", S_LAP, 20);
    applyStimulus(2'b10, 16'h0123, 40);
`ifdef BTN_HOLD_CLEAR_EN
    checkOutput("hold_cleared_state", 16'(bus.state), 16'(S_IDLE));
    checkOutput("hold_cleared_run_en", 16'(bus.run_en), 16'h0000);
    checkOutput("hold_single_pulse", 16'(clear_count - c0), 16'h0001);
    applyStimulus(2'b00, 16'h0123, 24);
    applyStimulus(2'b10, 16'h0123, 50);
    checkOutput("rehold_second_pulse", 16'(clear_count - c0), 16'h0002);
    checkOutput("rehold_state", 16'(bus.state), 16'(S_IDLE));
    applyStimulus(2'b00, 16'h0123, 24);
`else
    checkOutput("hold_is_single_press", 16'(bus.state), 16'(S_LAP));
    checkOutput("hold_no_clear", 16'(clear_count - c0), 16'h0000);
    checkOutput("hold_lap_disp", bus.disp_value, 16'h0123);
    applyStimulus(2'b00, 16'h0123, 24);
    checkOutput("hold_release_lap", 16'(bus.state), 16'(S_LAP));
`endif

    applyStimulus(2'b00, 16'h0000, 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
